uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and counter-width helper.
// Used by uart_rx and uart_tx. The s_parity state exists only when
// UART_RX_PARITY_EN is defined; otherwise the state fits in 2 bits.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    s_idle   = 3'd0,
    s_start  = 3'd1,
    s_data   = 3'd2,
    s_stop   = 3'd3,
    s_parity = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_start = 2'd1,
    s_data  = 2'd2,
    s_stop  = 2'd3
  } uart_state_e;
`endif

  // A down-counter that is loaded with n needs one bit beyond $clog2(n)
  // so that n itself (e.g. an exact power of two) is representable.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both stages reset to
// p_rst_val so the synchronized output is well defined straight out of reset.
module sync_2ff #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values are simply a one-stage shift.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= p_rst_val;
      sync_q <= p_rst_val;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first assembly, write-side FIFO
// strobe, and single-cycle frame-error / overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, plus the o_parity_err pulse output.
//
// Handshake: o_fifo_wr_en is a one-cycle write strobe qualified by
// i_fifo_full, which is sampled only in the stop-event cycle; a frame that
// meets a full FIFO is dropped and reported on o_overrun instead.
module uart_rx
  import uart_pkg::*;
#(
  parameter int p_delay_cnt = 434,
  parameter int p_bit_cnt   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sig,
  output logic [p_bit_cnt-1:0] o_fifo_wr_data,
  output logic                 o_fifo_wr_en,
  input  logic                 i_fifo_full,
  output logic                 o_frame_err,
  output logic                 o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int c_dw = cnt_width(p_delay_cnt);
  localparam int c_bw = cnt_width(p_bit_cnt);

  localparam logic [c_dw-1:0] c_full  = c_dw'(p_delay_cnt);
  localparam logic [c_dw-1:0] c_half  = c_dw'(p_delay_cnt / 2);
  localparam logic [c_bw-1:0] c_nbits = c_bw'(p_bit_cnt);

  logic sig_s;

  uart_state_e          state_q, state_d;
  logic [c_dw-1:0]      dly_q, dly_d;
  logic [c_bw-1:0]      bits_q, bits_d;
  logic [p_bit_cnt-1:0] shift_q, shift_d;
  logic [p_bit_cnt-1:0] wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  // Cleared by a frame error so a held-low break cannot restart reception
  // until the line has been seen high again.
  logic                 armed_q, armed_d;
  logic                 dly_evt;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  sync_2ff #(.p_rst_val(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sig),
    .o_q     (sig_s)
  );

  // The sample point fires in the cycle the delay counter reads 1.
  always_comb begin
    dly_evt = (dly_q == c_dw'(1));
  end

  // Next-state, counters, shift register and output pulses.
  always_comb begin
    state_d   = state_q;
    dly_d     = (dly_q != '0) ? (dly_q - c_dw'(1)) : '0;
    bits_d    = bits_q;
    shift_d   = shift_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    armed_d   = armed_q | sig_s;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      s_idle: begin
        if (armed_q && !sig_s) begin
          dly_d   = c_half;
          state_d = s_start;
        end
      end

      s_start: begin
        if (dly_evt) begin
          if (!sig_s) begin
            dly_d   = c_full;
            bits_d  = c_nbits;
            state_d = s_data;
`ifdef UART_RX_PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_d = s_idle;
          end
        end
      end

      s_data: begin
        if (dly_evt) begin
          shift_d                = shift_q >> 1;
          shift_d[p_bit_cnt-1]   = sig_s;
          dly_d                  = c_full;
`ifdef UART_RX_PARITY_EN
          par_d                  = par_q ^ sig_s;
`endif
          if (bits_q == c_bw'(1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = s_parity;
`else
            state_d = s_stop;
`endif
          end else begin
            bits_d = bits_q - c_bw'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      s_parity: begin
        if (dly_evt) begin
          par_d   = par_q ^ sig_s;
          dly_d   = c_full;
          state_d = s_stop;
        end
      end
`endif

      s_stop: begin
        if (dly_evt) begin
          // Leaving at mid-stop-bit keeps a back-to-back start edge visible.
          state_d = s_idle;
          if (!sig_s) begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          end else if (par_q) begin
            perr_d  = 1'b1;
`endif
          end else if (i_fifo_full) begin
            ovr_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
          end
        end
      end

      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= s_idle;
      dly_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_fifo_wr_data = wr_data_q;
  assign o_fifo_wr_en   = wr_en_q;
  assign o_frame_err    = ferr_q;
  assign o_overrun      = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (D=16, N=8). Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int D = 16;
  localparam int N = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sig   = 1'b1;
  logic full  = 1'b0;

  logic [N-1:0] wr_data;
  logic         wr_en;
  logic         ferr;
  logic         ovr;
`ifdef UART_RX_PARITY_EN
  logic         perr;
`endif

  always #5 clk = ~clk;

  uart_rx #(.p_delay_cnt(D), .p_bit_cnt(N)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sig          (sig),
    .o_fifo_wr_data (wr_data),
    .o_fifo_wr_en   (wr_en),
    .i_fifo_full    (full),
    .o_frame_err    (ferr),
    .o_overrun      (ovr)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err   (perr)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_wr = '0;
  int wr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor samples outputs on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: got data 0x%0h with empty expected queue", wr_data);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("wr_data", int'(wr_data), int'(e));
        last_wr = e;
      end
    end
    if (ferr) ferr_cnt++;
    if (ovr)  ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (perr) perr_cnt++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    sig = b;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < N; i++) send_bit(d[i]);
    if (P == 1) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    sig = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] data;
    logic         stop;
    logic         full;
    logic         par_ok;
    int           exp_wr;
    int           exp_ferr;
    int           exp_ovr;
    int           exp_perr;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] d, input logic stop,
                              input logic f, input logic par_ok);
    vec_t v;
    logic pe;
    pe         = (P == 1) && stop && !par_ok;
    v.data     = d;
    v.stop     = stop;
    v.full     = f;
    v.par_ok   = par_ok;
    v.exp_perr = int'(pe);
    v.exp_ferr = int'(!stop);
    v.exp_ovr  = int'(stop && f && !pe);
    v.exp_wr   = int'(stop && !f && !pe);
    return v;
  endfunction

  vec_t vecs[10];

  int w0, f0, o0, p0, lat;
  logic [N-1:0] tmp;

  initial begin
    vecs[0] = mk(8'h55, 1'b1, 1'b0, 1'b1);
    vecs[1] = mk(8'h3C, 1'b1, 1'b1, 1'b1);
    vecs[2] = mk(8'hA3, 1'b0, 1'b0, 1'b1);
    vecs[3] = mk(8'h00, 1'b1, 1'b0, 1'b1);
    vecs[4] = mk(8'hFF, 1'b1, 1'b0, 1'b1);
    vecs[5] = mk(8'h3C, 1'b0, 1'b1, 1'b1);
    vecs[6] = mk(N'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
    vecs[7] = mk(N'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
    vecs[8] = mk(N'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    vecs[9] = mk(N'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_frame_err", int'(ferr), 0);
    check("reset_overrun", int'(ovr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;
    idle(5);

    // Latency of a clean 0x55 frame, counted in rising edges from driving low
    exp_q.push_back(8'h55);
    w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, ^tmp | 1'b0 ? 1'b0 : (^(8'h55 & 8'hFF)));
      begin
        for (int k = 1; k <= 400; k++) begin
          @(posedge clk);
          #1;
          if (wr_en) begin
            lat = k;
            break;
          end
        end
      end
    join
    idle(2 * D);
    check("latency_0x55", lat, 2 + 1 + D / 2 + (N + 1 + P) * D);
    check("latency_wr_count", wr_cnt - w0, 1);
    check("latency_no_ferr", ferr_cnt - f0, 0);
    check("latency_no_ovr", ovr_cnt - o0, 0);

    // Short low glitch on an idle line
    w0 = wr_cnt; f0 = ferr_cnt;
    sig = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * D);
    check("glitch_no_write", wr_cnt - w0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
      full = vecs[i].full;
      if (vecs[i].exp_wr == 1) exp_q.push_back(vecs[i].data);
      tmp = vecs[i].data;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_ok ? ^tmp : ~^tmp);
      idle(2 * D);
      full = 1'b0;
      check($sformatf("vec%0d_wr", i),   wr_cnt - w0,   vecs[i].exp_wr);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i),  ovr_cnt - o0,  vecs[i].exp_ovr);
      check($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      check($sformatf("vec%0d_data_hold", i), int'(wr_data), int'(last_wr));
    end

    // Frame error followed by a held-low break
    w0 = wr_cnt; f0 = ferr_cnt;
    tmp = 8'hA3;
    send_frame(8'hA3, 1'b0, ^tmp);
    repeat (100) @(negedge clk);
    check("break_one_ferr", ferr_cnt - f0, 1);
    check("break_no_write", wr_cnt - w0, 0);
    idle(2 * D);
    check("break_release_no_ferr", ferr_cnt - f0, 1);

    // Back-to-back frames with no idle gap
    w0 = wr_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    tmp = 8'hA3;
    send_frame(8'hA3, 1'b1, ^tmp);
    tmp = 8'h0F;
    send_frame(8'h0F, 1'b1, ^tmp);
    idle(2 * D);
    check("b2b_two_writes", wr_cnt - w0, 2);

    // Reset pulse during data bit 4 discards the frame
    w0 = wr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    tmp = 8'hF0;
    fork
      send_frame(8'hF0, 1'b1, ^tmp);
      begin
        repeat (D + 4 * D + D / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_wr = '0;
        check("midreset_wr_en", int'(wr_en), 0);
        check("midreset_ferr", int'(ferr), 0);
        check("midreset_ovr", int'(ovr), 0);
        check("midreset_wr_data", int'(wr_data), 0);
      end
    join
    idle(3 * D);
    check("midreset_no_write", wr_cnt - w0, 0);
    check("midreset_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    w0 = wr_cnt;
    exp_q.push_back(8'h81);
    tmp = 8'h81;
    send_frame(8'h81, 1'b1, ^tmp);
    idle(2 * D);
    check("after_reset_write", wr_cnt - w0, 1);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has odd weight, so parity bit 1 is correct
    w0 = wr_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * D);
    check("parity_bad_perr", perr_cnt - p0, 1);
    check("parity_bad_no_write", wr_cnt - w0, 0);
    w0 = wr_cnt; p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * D);
    check("parity_good_no_perr", perr_cnt - p0, 0);
    check("parity_good_write", wr_cnt - w0, 1);
`endif

    check("exp_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
